// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: access sizes, arbiter state
// and the size/alignment legality rule applied to every granted access.
package dmem_pkg;

    localparam int NUM_PORTS = 2;

    localparam logic [2:0] SZ_B  = 3'b000;
    localparam logic [2:0] SZ_H  = 3'b001;
    localparam logic [2:0] SZ_W  = 3'b010;
    localparam logic [2:0] SZ_BU = 3'b100;
    localparam logic [2:0] SZ_HU = 3'b101;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_t;

    // Unsigned sizes only make sense for loads; H needs even, W needs 4-byte alignment.
    function automatic logic access_legal(input logic is_store, input logic [2:0] sz,
                                          input logic [1:0] lo);
        logic ok;
        ok = 1'b0;
        case (sz)
            SZ_B:    ok = 1'b1;
            SZ_BU:   ok = !is_store;
            SZ_H:    ok = !lo[0];
            SZ_HU:   ok = !is_store && !lo[0];
            SZ_W:    ok = (lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Two-way winner select: round-robin tie break while idle, owner-only while locked.
module rr_pick2
    import dmem_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 rr_ptr,
    input  arb_state_t           state,
    input  logic                 owner,
    output logic [NUM_PORTS-1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (state == LOCKED) begin
            if (req[owner]) begin
                gnt[owner] = 1'b1;
            end
        end else begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = rr_ptr ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port data-memory arbiter with round-robin, bounded lock for atomic
// sequences, legality checking and a registered one-cycle response.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter int LOCK_MAX = 16,
    parameter int ADDR_W   = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_PORTS-1:0]              req,
    input  logic [NUM_PORTS-1:0]              lock,
    input  logic [NUM_PORTS-1:0]              we,
    input  logic [NUM_PORTS-1:0][ADDR_W-1:0]  addr,
    input  logic [NUM_PORTS-1:0][31:0]        wData,
    input  logic [NUM_PORTS-1:0][2:0]         size,
    output logic [NUM_PORTS-1:0]              gnt,
    output logic [NUM_PORTS-1:0]              rValid,
    output logic [31:0]                       rData,
    output logic [NUM_PORTS-1:0]              err,
    output logic                              lockTimeout,
    output logic [ADDR_W-1:0]                 memAddr,
    output logic [31:0]                       memWData,
    output logic [2:0]                        memSize,
    output logic                              memWEn,
    input  logic [31:0]                       memRData,
    output arb_state_t                        dbg_state
);

    localparam int CW = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(LOCK_MAX - 1);

    // Handshake: a port holds req and its fields until gnt; gnt means the
    // access is taken this cycle and rValid answers exactly one cycle later.
    arb_state_t           state, state_n;
    logic                 owner, owner_n;
    logic                 rr_ptr, rr_ptr_n;
    logic [CW-1:0]        lock_cnt, lock_cnt_n;
    logic                 timeout_n;
    logic [NUM_PORTS-1:0] pick_gnt;
    logic                 win;
    logic                 granted;
    logic                 legal;

    rr_pick2 u_pick (
        .req    (req),
        .rr_ptr (rr_ptr),
        .state  (state),
        .owner  (owner),
        .gnt    (pick_gnt)
    );

    assign gnt       = pick_gnt & {NUM_PORTS{~reset}};
    assign win       = gnt[1];
    assign granted   = |gnt;
    assign legal     = access_legal(we[win], size[win], addr[win][1:0]);
    assign dbg_state = state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            rr_ptr      <= 1'b0;
            lock_cnt    <= '0;
            lockTimeout <= 1'b0;
        end else begin
            state       <= state_n;
            owner       <= owner_n;
            rr_ptr      <= rr_ptr_n;
            lock_cnt    <= lock_cnt_n;
            lockTimeout <= timeout_n;
        end
    end

    always_comb begin
        state_n    = state;
        owner_n    = owner;
        rr_ptr_n   = rr_ptr;
        lock_cnt_n = lock_cnt;
        timeout_n  = 1'b0;
        case (state)
            IDLE: begin
                if (granted) begin
                    rr_ptr_n = ~win;
                    if (lock[win]) begin
                        state_n    = LOCKED;
                        owner_n    = win;
                        lock_cnt_n = '0;
                    end
                end
            end
            LOCKED: begin
                lock_cnt_n = lock_cnt + 1'b1;
                // A normal release takes priority over a simultaneous timeout.
                if (gnt[owner] && !lock[owner]) begin
                    state_n    = IDLE;
                    rr_ptr_n   = ~owner;
                    lock_cnt_n = '0;
                end else if (lock_cnt == CNT_LAST) begin
                    state_n    = IDLE;
                    rr_ptr_n   = ~owner;
                    lock_cnt_n = '0;
                    timeout_n  = 1'b1;
                end
            end
            default: begin
                state_n    = IDLE;
                lock_cnt_n = '0;
            end
        endcase
    end

    always_comb begin
        memAddr  = '0;
        memWData = '0;
        memSize  = SZ_W;
        memWEn   = 1'b0;
        if (granted) begin
            memAddr  = addr[win];
            memWData = wData[win];
            memSize  = size[win];
            memWEn   = we[win] & legal;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rValid <= '0;
            err    <= '0;
            rData  <= '0;
        end else begin
            rValid <= gnt;
            err    <= (granted && !legal) ? gnt : '0;
            if (granted) begin
                if (!legal) begin
                    rData <= '0;
                end else if (!we[win]) begin
                    rData <= memRData;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a byte-addressed memory model behind it.
module tb_dmem_arbiter;
    import dmem_pkg::*;

    logic             clk;
    logic             reset;
    logic [1:0]       req;
    logic [1:0]       lock;
    logic [1:0]       we;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] wData;
    logic [1:0][2:0]  size;
    logic [1:0]       gnt;
    logic [1:0]       rValid;
    logic [31:0]      rData;
    logic [1:0]       err;
    logic             lockTimeout;
    logic [31:0]      memAddr;
    logic [31:0]      memWData;
    logic [2:0]       memSize;
    logic             memWEn;
    logic [31:0]      memRData;
    arb_state_t       dbg_state;

    int n_cmp = 0;
    int n_mis = 0;

    logic [7:0] mem [0:1023];
    logic [9:0] ba;
    logic [7:0] b0, b1, b2, b3;

    dmem_arbiter #(.LOCK_MAX(16), .ADDR_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .lock        (lock),
        .we          (we),
        .addr        (addr),
        .wData       (wData),
        .size        (size),
        .gnt         (gnt),
        .rValid      (rValid),
        .rData       (rData),
        .err         (err),
        .lockTimeout (lockTimeout),
        .memAddr     (memAddr),
        .memWData    (memWData),
        .memSize     (memSize),
        .memWEn      (memWEn),
        .memRData    (memRData),
        .dbg_state   (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model: combinational, extended read; clocked little-endian write.
    always_comb begin
        ba = memAddr[9:0];
        b0 = mem[ba];
        b1 = mem[ba + 10'd1];
        b2 = mem[ba + 10'd2];
        b3 = mem[ba + 10'd3];
        case (memSize)
            3'b000:  memRData = {{24{b0[7]}}, b0};
            3'b100:  memRData = {24'h0, b0};
            3'b001:  memRData = {{16{b1[7]}}, b1, b0};
            3'b101:  memRData = {16'h0, b1, b0};
            default: memRData = {b3, b2, b1, b0};
        endcase
    end

    always @(posedge clk) begin
        if (memWEn) begin
            mem[ba] <= memWData[7:0];
            if (memSize[1:0] != 2'b00) mem[ba + 10'd1] <= memWData[15:8];
            if (memSize[1]) begin
                mem[ba + 10'd2] <= memWData[23:16];
                mem[ba + 10'd3] <= memWData[31:24];
            end
        end
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] <= 8'h00;
        mem[256] <= 8'h22; mem[257] <= 8'h22; mem[258] <= 8'h11; mem[259] <= 8'h11;
        mem[512] <= 8'h44; mem[513] <= 8'h44; mem[514] <= 8'h33; mem[515] <= 8'h33;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_mis++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_port(input int p, input logic r, input logic l, input logic w,
                            input logic [31:0] a, input logic [31:0] d, input logic [2:0] s);
        req[p]   = r;
        lock[p]  = l;
        we[p]    = w;
        addr[p]  = a;
        wData[p] = d;
        size[p]  = s;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        reset = 1'b1;
        req   = 2'b00;
        lock  = 2'b00;
        we    = 2'b00;
        addr  = '0;
        wData = '0;
        size  = {SZ_W, SZ_W};
        tick();
        tick();

        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_rvalid", 32'(rValid), 32'h0);
        chk("rst_rdata", rData, 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_timeout", 32'(lockTimeout), 32'h0);
        chk("rst_memwen", 32'(memWEn), 32'h0);
        chk("rst_state", 32'(dbg_state), 32'(IDLE));
        chk("rst_memsize", 32'(memSize), 32'h2);
        reset = 1'b0;

        // Alternating word reads from both ports.
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, SZ_W);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h200, 32'h0, SZ_W);
        #1;
        chk("rr_gnt_first", 32'(gnt), 32'h1);
        chk("rr_memaddr", memAddr, 32'h100);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rr_rvalid", 32'(rValid), (k % 2 == 0) ? 32'h1 : 32'h2);
            chk("rr_rdata", rData, (k % 2 == 0) ? 32'h11112222 : 32'h33334444);
            if (k == 3) req = 2'b00;
            if (k < 3) begin
                #1;
                chk("rr_gnt", 32'(gnt), (k % 2 == 0) ? 32'h2 : 32'h1);
            end
        end

        // Store then immediate load of the same word, plus byte loads.
        set_port(0, 1'b1, 1'b0, 1'b1, 32'h40, 32'hDEADBEEF, SZ_W);
        #1;
        chk("st_gnt", 32'(gnt), 32'h1);
        chk("st_memwen", 32'(memWEn), 32'h1);
        chk("st_memwdata", memWData, 32'hDEADBEEF);
        tick();
        chk("st_rvalid", 32'(rValid), 32'h1);
        chk("st_err", 32'(err), 32'h0);
        chk("st_rdata_hold", rData, 32'h33334444);
        req[0] = 1'b0;
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, SZ_W);
        #1;
        chk("ld_gnt", 32'(gnt), 32'h2);
        tick();
        chk("ld_rvalid", 32'(rValid), 32'h2);
        chk("ld_w", rData, 32'hDEADBEEF);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h43, 32'h0, SZ_BU);
        tick();
        chk("ld_bu", rData, 32'h000000DE);
        set_port(1, 1'b1, 1'b0, 1'b0, 32'h43, 32'h0, SZ_B);
        tick();
        chk("ld_b", rData, 32'hFFFFFFDE);
        req[1] = 1'b0;

        // Rejected accesses.
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h41, 32'h0, SZ_H);
        #1;
        chk("bad_h_gnt", 32'(gnt), 32'h1);
        chk("bad_h_memwen", 32'(memWEn), 32'h0);
        tick();
        chk("bad_h_rvalid", 32'(rValid), 32'h1);
        chk("bad_h_err", 32'(err), 32'h1);
        chk("bad_h_rdata", rData, 32'h0);
        set_port(0, 1'b1, 1'b0, 1'b1, 32'h42, 32'h12345678, SZ_W);
        #1;
        chk("bad_w_memwen", 32'(memWEn), 32'h0);
        tick();
        chk("bad_w_err", 32'(err), 32'h1);
        chk("bad_w_rdata", rData, 32'h0);
        set_port(0, 1'b1, 1'b0, 1'b1, 32'h40, 32'h0, SZ_BU);
        #1;
        chk("bad_sbu_memwen", 32'(memWEn), 32'h0);
        tick();
        chk("bad_sbu_err", 32'(err), 32'h1);
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h40, 32'h0, SZ_W);
        tick();
        chk("unchanged_err", 32'(err), 32'h0);
        chk("unchanged_data", rData, 32'hDEADBEEF);
        req[0] = 1'b0;

        // Port 1 holds a lock for three grants, then releases.
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, SZ_W);
        set_port(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, SZ_W);
        #1;
        chk("lk_gnt1", 32'(gnt), 32'h2);
        tick();
        chk("lk_state1", 32'(dbg_state), 32'(LOCKED));
        chk("lk_rvalid1", 32'(rValid), 32'h2);
        #1;
        chk("lk_gnt2", 32'(gnt), 32'h2);
        tick();
        chk("lk_state2", 32'(dbg_state), 32'(LOCKED));
        #1;
        chk("lk_gnt3", 32'(gnt), 32'h2);
        tick();
        lock[1] = 1'b0;
        #1;
        chk("lk_gnt_release", 32'(gnt), 32'h2);
        tick();
        chk("lk_state_idle", 32'(dbg_state), 32'(IDLE));
        chk("lk_rvalid_release", 32'(rValid), 32'h2);
        req[1] = 1'b0;
        #1;
        chk("lk_gnt_p0", 32'(gnt), 32'h1);
        tick();
        chk("lk_rvalid_p0", 32'(rValid), 32'h1);
        chk("lk_rdata_p0", rData, 32'h11112222);
        req[0] = 1'b0;

        // Port 1 locks and goes quiet until the lock times out.
        set_port(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, SZ_W);
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, SZ_W);
        #1;
        chk("to_gnt_lock", 32'(gnt), 32'h2);
        tick();
        req[1] = 1'b0;
        chk("to_rvalid", 32'(rValid), 32'h2);
        for (int k = 0; k < 16; k++) begin
            #1;
            chk("to_gnt_held", 32'(gnt), 32'h0);
            chk("to_no_pulse", 32'(lockTimeout), 32'h0);
            chk("to_state_locked", 32'(dbg_state), 32'(LOCKED));
            tick();
        end
        chk("to_pulse", 32'(lockTimeout), 32'h1);
        chk("to_state_idle", 32'(dbg_state), 32'(IDLE));
        #1;
        chk("to_gnt_p0", 32'(gnt), 32'h1);
        tick();
        chk("to_pulse_end", 32'(lockTimeout), 32'h0);
        chk("to_rvalid_p0", 32'(rValid), 32'h1);
        req[0] = 1'b0;

        // Reset in the middle of a locked sequence with an access in flight.
        set_port(1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h0, SZ_W);
        #1;
        chk("mr_gnt", 32'(gnt), 32'h2);
        tick();
        chk("mr_state_locked", 32'(dbg_state), 32'(LOCKED));
        reset = 1'b1;
        #1;
        chk("mr_gnt_in_reset", 32'(gnt), 32'h0);
        tick();
        chk("mr_rvalid", 32'(rValid), 32'h0);
        chk("mr_state", 32'(dbg_state), 32'(IDLE));
        chk("mr_timeout", 32'(lockTimeout), 32'h0);
        reset = 1'b0;
        set_port(0, 1'b1, 1'b0, 1'b0, 32'h100, 32'h0, SZ_W);
        #1;
        chk("mr_tie_p0", 32'(gnt), 32'h1);
        tick();
        chk("mr_rvalid_p0", 32'(rValid), 32'h1);
        chk("mr_rdata_p0", rData, 32'h11112222);
        req = 2'b00;
        tick();
        chk("mr_quiet", 32'(rValid), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single byte-addressed data-memory port between two requesters: port 0 is the core load/store unit, port 1 is the debug/DMA loader.
- Performs round-robin arbitration with an optional bounded lock, so a requester can do atomic read-modify-write sequences.
- Checks size and alignment before forwarding an access, and returns a registered read/ack one cycle after grant.
- Sits between the requesters and the dmem combinational-read / clocked-write port.

Parameters:
- LOCK_MAX, 16: maximum consecutive cycles in LOCKED before a forced release.
- ADDR_W, 32: address width.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req  in  2  per-port request; held stable until gnt.
- lock  in  2  per-port lock request, sampled with req.
- we  in  2  per-port write enable (1 = store).
- addr  in  2xADDR_W  per-port byte address.
- wData  in  2x32  per-port store data, little-endian.
- size  in  2x3  per-port funct3 size: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- gnt  out  2  one-hot combinational grant; the access is taken this cycle.
- rValid  out  2  one-cycle pulse, one cycle after gnt; read data or write ack.
- rData  out  32  registered read data, qualified by rValid.
- err  out  2  pulses with rValid when the access was rejected.
- lockTimeout  out  1  one-cycle pulse on forced lock release.
- memAddr  out  ADDR_W  to dmem.
- memWData  out  32  to dmem.
- memSize  out  3  to dmem.
- memWEn  out  1  to dmem.
- memRData  in  32  from dmem; combinational, already sign/zero-extended.

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high.
- Reset values:
  - gnt=0, rValid=0, rData=0, err=0, lockTimeout=0, memWEn=0.
  - rrPtr=0 (port 0 favoured), state=IDLE, lockCnt=0.
- IDLE arbitration:
  - If only one port requests, that port wins.
  - If both request, the port equal to rrPtr wins.
  - After any grant to port i, rrPtr <= ~i.
- LOCKED(owner):
  - Only the owner can be granted; the other port's req is held off (gnt=0) indefinitely until release.
  - rrPtr is frozen.
- Transitions:
  - IDLE -> LOCKED(i): on a grant to i with lock[i]=1; lockCnt <= 0.
  - LOCKED -> IDLE (normal release): on an owner grant with lock=0. That access is still performed. rrPtr <= ~owner.
  - LOCKED -> IDLE (timeout): if lockCnt reaches LOCK_MAX-1 with no release, go to IDLE and pulse lockTimeout. rrPtr <= ~owner. lockCnt counts every cycle in LOCKED.
  - If release and timeout occur in the same cycle, treat it as a normal release with no lockTimeout pulse.
- Legality check on the granted access: the access is rejected if any of the following hold:
  - size is 011, 110 or 111;
  - the access is a store with size 100 or 101;
  - an H/HU access has addr[0]=1;
  - a W access has addr[1:0]!=0.
- Rejected access:
  - Still granted; memWEn=0.
  - Next cycle: rValid[i]=1, err[i]=1, rData=0.
  - Lock state still updates from lock[i].
- Forwarding (grant cycle): memAddr/memWData/memSize come from the winner; memWEn=we & legal.
- No grant: memAddr=0, memWData=0, memSize=010, memWEn=0.
- Response (cycle after grant):
  - rValid[i]=1.
  - For a legal read, rData=memRData as captured at the grant edge.
  - For writes, rData holds its previous value.
- Throughput and latency: one access per cycle, back-to-back allowed; latency is exactly 1 cycle.
- Write then read: a store granted in cycle N and a load of the same address in cycle N+1 returns the new data.
- Reset mid-operation: an in-flight response is dropped (rValid=0 next cycle) and LOCKED is abandoned with no lockTimeout pulse.
- Requester obligations: a requester must not change its request fields while req=1 and gnt=0.

Decomposition:
- Shared package dmem_pkg holds:
  - size constants SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU;
  - the state enum arb_state_t {IDLE, LOCKED};
  - NUM_PORTS=2.
- One sub-module, rr_pick2: combinational two-way round-robin winner select from req, rrPtr, state and owner.

Test Plan:
- Both ports request word reads (0x100, 0x200) each cycle from reset -> grants alternate 0,1,0,1 starting with port 0; rValid follows gnt by 1 cycle with the correct data.
- Port 0 stores W 0xDEADBEEF at 0x40 in cycle N, port 1 loads W at 0x40 in cycle N+1 -> rValid[1] with rData=0xDEADBEEF; a BU load at 0x43 returns 0x000000DE, and a B load at 0x43 returns 0xFFFFFFDE.
- Port 0 issues a H load at 0x41, then a W store at 0x42 -> err[0] pulses each time, rData=0, memWEn never asserted, memory unchanged.
- Port 1 has lock=1 for 3 grants and port 0 requests continuously -> port 0 gnt=0 throughout; after port 1's lock=0 access, port 0 is granted next cycle.
- Port 1 locks and idles with LOCK_MAX=16 -> lockTimeout pulses after 16 LOCKED cycles, then port 0 is granted.
- Reset asserted in the cycle after a grant -> rValid stays 0, state is IDLE, and port 0 wins the first tie after reset.
